// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller.
// Holds the default data/index widths, the ALU op-code encoding and the
// controller FSM state encoding. No ports.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpSlt   = 3'b101,
    OpMov   = 3'b110,
    OpClear = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWrite = 3'd3,
    StClear = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU for the register-file controller.
// Ports:
//   op     in  3       operation code (op_e encoding)
//   a      in  DATA_W  operand A
//   b      in  DATA_W  operand B
//   result out DATA_W  operation result (ADD/SUB wrap, SLT is signed)
module regfile_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic a_lt_b;
  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    unique case (op_e'(op))
      OpAdd:   result = a + b;
      OpSub:   result = a - b;
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpSlt:   result = {{(DATA_W-1){1'b0}}, a_lt_b};
      OpMov:   result = a;
      OpClear: result = '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_controller.sv
// Register-file controller: accepts one command at a time, reads two source
// registers from an external register file, runs them through the ALU and
// writes the result back. Op CLEAR instead zeroes all 2^ADDR_W registers.
// Ports:
//   clk, reset                clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/cmd_sr1/sr2/dr     command fields, latched on accept
//   sr1, sr2 / rdData1, 2     register-file read addresses / read data
//   dr, wrData, write         register-file write port
//   done, result              completion pulse and the value just written
module regfile_controller
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_sr1,
  input  logic [ADDR_W-1:0] cmd_sr2,
  input  logic [ADDR_W-1:0] cmd_dr,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrData,
  output logic              write,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] sr1_q, sr2_q, dr_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] alu_q, alu_res;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              idle_ready;
  logic              accept;

  regfile_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  // Ready is gated by reset so it stays low while reset is held and rises
  // as soon as reset is released.
  assign cmd_ready = idle_ready & reset;
  assign accept    = cmd_valid & cmd_ready;

  assign sr1 = sr1_q;
  assign sr2 = sr2_q;

  always_comb begin
    state_d    = state_q;
    idle_ready = 1'b0;
    write      = 1'b0;
    done       = 1'b0;
    dr         = '0;
    wrData     = '0;
    result     = result_q;
    unique case (state_q)
      StIdle: begin
        idle_ready = 1'b1;
        if (cmd_valid && reset) begin
          state_d = (op_e'(cmd_op) == OpClear) ? StClear : StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: begin
        write   = 1'b1;
        dr      = dr_q;
        wrData  = alu_q;
        done    = 1'b1;
        result  = alu_q;
        state_d = StIdle;
      end
      StClear: begin
        write = 1'b1;
        dr    = clr_cnt_q;
        if (&clr_cnt_q) begin
          done    = 1'b1;
          result  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= OpAdd;
      sr1_q     <= '0;
      sr2_q     <= '0;
      dr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      result_q  <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        sr1_q <= cmd_sr1;
        sr2_q <= cmd_sr2;
        dr_q  <= cmd_dr;
      end
      if (state_q == StFetch) begin
        a_q <= rdData1;
        b_q <= rdData2;
      end
      if (state_q == StExec) begin
        alu_q <= alu_res;
      end
      // Counter wraps to 0 on the final CLEAR cycle, ready for the next one.
      if (state_q == StClear) begin
        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      end
      if (done) begin
        result_q <= result;
      end
    end
  end

endmodule

// File: tb/tb_regfile_controller.sv
// Scoreboard bench for regfile_controller with a behavioural register file.
module tb_regfile_controller;
  import regfile_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_sr1, cmd_sr2, cmd_dr;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] rdData1, rdData2, wrData, result;
  logic        write, done;

  always #5 clk = ~clk;

  regfile_controller #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sr1   (cmd_sr1),
    .cmd_sr2   (cmd_sr2),
    .cmd_dr    (cmd_dr),
    .sr1       (sr1),
    .sr2       (sr2),
    .rdData1   (rdData1),
    .rdData2   (rdData2),
    .dr        (dr),
    .wrData    (wrData),
    .write     (write),
    .done      (done),
    .result    (result)
  );

  // External register file driven by the DUT.
  logic [31:0] rf [32];
  assign rdData1 = rf[sr1];
  assign rdData2 = rf[sr2];
  always @(posedge clk) if (write) rf[dr] <= wrData;

  typedef struct {
    int          cyc;
    logic [4:0]  d;
    logic [31:0] v;
    bit          last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_rf [32];
  logic [31:0] saved_rf [32];
  logic [31:0] last_res;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every write must match the next scoreboard entry.
  initial begin
    exp_t e;
    last_res = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_res = '0;
      end else if (write) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got dr=%0d data=%h expected no write", dr, wrData);
        end else begin
          e = sb_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", {27'd0, dr}, {27'd0, e.d});
          chk("wr_data", wrData, e.v);
          chk("done_flag", {31'd0, done}, {31'd0, e.last});
          if (e.last) begin
            chk("done_result", result, e.v);
            last_res = e.v;
          end
        end
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
        chk("result_hold", result, last_res);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    rf[idx]     <= val;
    ref_rf[idx] = val;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Issue one command; called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input bit noise, output int acc);
    bit          rdy;
    int          n;
    logic [31:0] v;
    exp_t        e;
    n         = 0;
    acc       = -1;
    cmd_op    = op;
    cmd_sr1   = s1;
    cmd_sr2   = s2;
    cmd_dr    = d;
    cmd_valid = 1'b1;
    do begin
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (op == 3'd7) begin
      for (int i = 0; i < 32; i++) begin
        e = '{acc + i, 5'(i), 32'd0, (i == 31)};
        sb_q.push_back(e);
        ref_rf[i] = '0;
      end
    end else begin
      // Sources are read before the destination is written.
      v = ref_alu(op, ref_rf[s1], ref_rf[s2]);
      e = '{acc + 2, d, v, 1'b1};
      sb_q.push_back(e);
      ref_rf[d] = v;
    end
    if (noise) begin
      for (int i = 0; i < 3; i++) begin
        cmd_op    = 3'($urandom);
        cmd_sr1   = 5'($urandom);
        cmd_sr2   = 5'($urandom);
        cmd_dr    = 5'($urandom);
        cmd_valid = 1'b1;
        chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, a1, a2;
    logic [2:0] op;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_sr1   = '0;
    cmd_sr2   = '0;
    cmd_dr    = '0;
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sr1", {27'd0, sr1}, 32'd0);
    chk("rst_sr2", {27'd0, sr2}, 32'd0);
    chk("rst_dr", {27'd0, dr}, 32'd0);
    chk("rst_wrdata", wrData, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;

    // CLEAR: 32 writes, busy for 32 cycles.
    send(3'd7, 5'd0, 5'd0, 5'd0, 1'b0, a1);
    wait_idle(n);
    chk("clear_busy_cycles", n, 32);

    preload(1, 32'd5);
    preload(2, 32'hFFFF_FFFF);
    send(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, a1);
    wait_idle(n);
    chk("alu_busy_cycles", n, 3);
    chk("r3_add", rf[3], 32'd4);
    send(3'd5, 5'd2, 5'd1, 5'd4, 1'b0, a1);
    wait_idle(n);
    chk("r4_slt", rf[4], 32'd1);
    send(3'd1, 5'd2, 5'd1, 5'd5, 1'b0, a1);
    wait_idle(n);
    chk("r5_sub", rf[5], 32'hFFFF_FFFA);

    // Back-to-back with valid held high.
    send(3'd6, 5'd3, 5'd0, 5'd6, 1'b0, a1);
    send(3'd0, 5'd6, 5'd6, 5'd6, 1'b0, a2);
    chk("b2b_gap", a2 - a1, 4);
    wait_idle(n);
    chk("r6_b2b", rf[6], 32'd8);

    // Field noise with valid high while busy.
    send(3'd0, 5'd1, 5'd1, 5'd7, 1'b1, a1);
    wait_idle(n);
    chk("r7_noise", rf[7], 32'd10);
    send(3'd0, 5'd1, 5'd1, 5'd1, 1'b0, a1);
    send(3'd3, 5'd0, 5'd5, 5'd0, 1'b0, a1);
    send(3'd4, 5'd0, 5'd2, 5'd8, 1'b1, a1);
    send(3'd2, 5'd8, 5'd5, 5'd9, 1'b0, a1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        wait_idle(n);
        preload(int'($urandom_range(31, 0)), $urandom);
      end
      op = 3'($urandom_range(6, 0));
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), bit'($urandom_range(1, 0)), a1);
      if ($urandom_range(1, 0) == 1) wait_idle(n);
    end
    wait_idle(n);

    // Reset in the dr=10 cycle of a CLEAR.
    for (int i = 0; i < 32; i++) preload(i, (i == 10) ? 32'd0 : ($urandom | 32'd1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) saved_rf[i] = ref_rf[i];
    send(3'd7, 5'd0, 5'd0, 5'd0, 1'b0, a1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("clr_dr_before_reset", {27'd0, dr}, 32'd10);
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_reset_write", {31'd0, write}, 32'd0);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    chk("mid_reset_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 32; i++) ref_rf[i] = (i < 10) ? 32'd0 : saved_rf[i];
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("ready_after_mid_reset", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(3'd4, 5'd11, 5'd12, 5'd13, 1'b0, a1);
    wait_idle(n);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) chk($sformatf("final_rf_%0d", i), rf[i], ref_rf[i]);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
